det_scan_arbiter: RTL and testbench
===================================

# det_scan_arbiter

Round-robin scheduler that shares a single 1011 Mealy sequence detector between `NUM_REQ` requesters. It grants one requester at a time and captures that requester's parallel word. The word is shifted MSB-first through the detector, and the number of 1011 hits is returned with the requester's ID. It sits between the parallel capture channels and the serial detection datapath of the sequential-circuit group.

## Interface
- `NUM_REQ`, default 4: number of requester channels (2..8).
- `WORD_W`, default 8: bits per scanned word (4..32).
- `CNT_W`, default 4: hit counter width; the counter saturates at 2^CNT_W-1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `i_req`  in  NUM_REQ: per-channel request level.
- `i_word`  in  NUM_REQ*WORD_W: channel k's word in bits [k*WORD_W +: WORD_W].
- `o_gnt`  out  NUM_REQ: one-hot grant, one-cycle pulse.
- `o_busy`  out  1: high while any word is in flight (LOAD, SHIFT or DONE).
- `o_done`  out  1: one-cycle pulse marking that the result is valid.
- `o_done_id`  out  $clog2(NUM_REQ): index of the channel that was served.
- `o_hits`  out  CNT_W: hit count for the served word; held until the next `o_done`.
- `o_seq`  out  1: bit currently presented to the detector (debug).
- `o_det`  out  1: combinational Mealy detect output of the detector (debug).

## Operation
- FSM states are IDLE, LOAD, SHIFT and DONE.
- **IDLE:** if any `i_req` is high, go to LOAD; otherwise stay in IDLE.
- **LOAD:**
  - Choose the winner by round-robin, searching upward from pointer `rr_ptr` and wrapping.
  - Assert `o_gnt[winner]`.
  - Latch the winner's word into the shift register.
  - Clear the detector to its idle state and clear the hit counter.
  - Set `rr_ptr` to winner+1 mod NUM_REQ.
  - Go to SHIFT.
- **SHIFT:**
  - Present the shift register MSB on `o_seq` and shift left each cycle.
  - If `o_det` is high on an edge, increment the hit counter, saturating.
  - After WORD_W bits, go to DONE.
- **DONE:**
  - Pulse `o_done`, drive `o_done_id` with the winner and register `o_hits`.
  - If any `i_req` is high, go to LOAD; otherwise go to IDLE.
- Detector history does not carry across words; each word is scanned from the idle state.
- Requester rules:
  - Hold `i_req` and the word stable until `o_gnt` is seen.
  - Drop `i_req` the cycle after the grant.
  - `i_req` still high in DONE counts as a new request.
  - Dropping `i_req` before it is granted withdraws the request with no side effects.
- Requests arriving during SHIFT wait; there is no preemption.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE and `rr_ptr` is 0.
  - The detector is idle and the shift register is 0.
- Reset asserted mid-scan aborts the word immediately: no `o_done` is produced and `o_hits` returns to 0.

## Timing
- When a request is sampled in IDLE at edge 0:
  - `o_gnt` is high in cycle 1.
  - Bits are presented in cycles 2..WORD_W+1.
  - `o_done` is high in cycle WORD_W+2.
- Back-to-back service (DONE→LOAD) gives a period of WORD_W+2 cycles per word.
- `o_busy` is high from the LOAD cycle through the DONE cycle.
- If `o_det` is high on the final SHIFT edge, that hit is counted in the `o_hits` reported in DONE.

## Configuration
- Macro `DET_SCAN_OVERLAP_EN`.
- **Defined:** overlapping matches are counted; after a hit the detector moves to state S1 (last bit was 1).
- **Undefined:** after a hit the detector returns to idle, so matches never share bits.

## Structure
- Package `det_scan_pkg` holds:
  - `scan_state_t`, the enum {IDLE, LOAD, SHIFT, DONE};
  - `det_state_t`, the enum {S_IDLE, S_1, S_10, S_101};
  - the pattern constant 4'b1011.
- Sub-module `det1011_core` contains the Mealy detector, with ports `clk`, `rst`, synchronous `i_clr`, `i_en`, `i_seq` and `o_det`. The overlap macro applies inside this sub-module.
- Top level contains the round-robin pointer, FSM, shift register and saturating counter.

## Test plan
- Reset, then `i_req`=4'b0001 with word 0 = 8'hB0 → `o_gnt`=0001 at cycle 1; `o_done` at cycle 10 with `o_done_id`=0 and `o_hits`=1.
- Word 8'hB6 (bits 10110110) → `o_hits`=2 with `DET_SCAN_OVERLAP_EN`, and 1 without it.
- Word 8'hFF → `o_hits`=0.
- Word 8'h00 → `o_hits`=0.
- `i_req`=4'b1111 held continuously → grant order 0,1,2,3,0; `o_done` spaced exactly 10 cycles apart.
- Request to channel 2 during the SHIFT of channel 0 → served in the LOAD that directly follows DONE, with no IDLE cycle between.
- `rst` asserted at the 4th SHIFT cycle → all outputs 0 asynchronously; no `o_done`; the next request is granted starting from channel 0.

Source files
------------

// File: rtl/det_scan_pkg.sv
// Shared types and constants for det_scan_arbiter and its 1011 detector core.
// The overlap behaviour is selected by DET_SCAN_OVERLAP_EN inside det1011_core.
package det_scan_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} scan_state_t;

    typedef enum logic [1:0] {S_IDLE, S_1, S_10, S_101} det_state_t;

    localparam logic [3:0] DET_PATTERN = 4'b1011;

endpackage

// File: rtl/det1011_core.sv
// Mealy 1011 detector, fed one bit per enabled cycle, synchronously clearable.
// DET_SCAN_OVERLAP_EN defined: a hit leaves the detector in S_1 so matches may share a bit.
module det1011_core
    import det_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_seq,
    output logic o_det
);

    det_state_t state_q, state_d;
    logic       hit;

    assign hit   = (state_q == S_101) && (i_seq == DET_PATTERN[0]);
    assign o_det = i_en && hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clr) begin
            state_d = S_IDLE;
        end else if (i_en) begin
            case (state_q)
                S_IDLE: state_d = (i_seq == DET_PATTERN[3]) ? S_1   : S_IDLE;
                S_1:    state_d = (i_seq == DET_PATTERN[2]) ? S_10  : S_1;
                S_10:   state_d = (i_seq == DET_PATTERN[1]) ? S_101 : S_IDLE;
                S_101: begin
                    // A 0 here leaves "10" as the longest useful suffix.
                    if (!hit) begin
                        state_d = S_10;
                    end else begin
`ifdef DET_SCAN_OVERLAP_EN
                        state_d = S_1;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/det_scan_arbiter.sv
// Round-robin scheduler sharing one 1011 detector between NUM_REQ word channels.
// Overlapping-match counting is enabled by defining DET_SCAN_OVERLAP_EN.
module det_scan_arbiter
    import det_scan_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*WORD_W-1:0]  i_word,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [$clog2(NUM_REQ)-1:0] o_done_id,
    output logic [CNT_W-1:0]           o_hits,
    output logic                       o_seq,
    output logic                       o_det
);

    localparam int               ID_W     = $clog2(NUM_REQ);
    localparam int               BIT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] HIT_MAX  = '1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    scan_state_t        state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    win_id_q, win_id_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic [CNT_W-1:0]   res_hits_q, res_hits_d;

    logic [WORD_W-1:0]  words [NUM_REQ];
    logic [NUM_REQ-1:0] req_rot;
    logic               win_vld;
    logic [ID_W-1:0]    win_idx, win_nxt;
    logic               det_clr, det_en;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign words[k] = i_word[k*WORD_W +: WORD_W];
    end

    // Rotate requests so bit 0 is the channel at rr_ptr, then take the first set bit.
    always_comb begin
        int off;
        int sum;
        req_rot = NUM_REQ'({i_req, i_req} >> rr_ptr_q);
        win_vld = 1'b0;
        off     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && req_rot[i]) begin
                win_vld = 1'b1;
                off     = i;
            end
        end
        sum = int'(rr_ptr_q) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win_idx = ID_W'(sum);
        win_nxt = (sum == NUM_REQ - 1) ? '0 : ID_W'(sum + 1);
    end

    det1011_core u_det (
        .clk   (clk),
        .rst   (rst),
        .i_clr (det_clr),
        .i_en  (det_en),
        .i_seq (o_seq),
        .o_det (o_det)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            win_id_q   <= '0;
            res_id_q   <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            hits_q     <= '0;
            res_hits_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_id_q   <= win_id_d;
            res_id_q   <= res_id_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            hits_q     <= hits_d;
            res_hits_q <= res_hits_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_id_d   = win_id_q;
        res_id_d   = res_id_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        hits_d     = hits_q;
        res_hits_d = res_hits_q;
        o_gnt      = '0;
        det_clr    = 1'b0;
        det_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|i_req) state_d = LOAD;
            end
            LOAD: begin
                // A request withdrawn before grant just falls back to IDLE.
                if (win_vld) begin
                    o_gnt[win_idx] = 1'b1;
                    shreg_d        = words[win_idx];
                    win_id_d       = win_idx;
                    rr_ptr_d       = win_nxt;
                    det_clr        = 1'b1;
                    hits_d         = '0;
                    bit_cnt_d      = '0;
                    state_d        = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                det_en    = 1'b1;
                shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (o_det && (hits_q != HIT_MAX)) hits_d = hits_q + 1'b1;
                // Result registers load on the last bit so they are valid during DONE.
                if (bit_cnt_q == LAST_BIT) begin
                    res_hits_d = hits_d;
                    res_id_d   = win_id_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = (|i_req) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_seq     = (state_q == SHIFT) && shreg_q[WORD_W-1];
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_done_id = res_id_q;
    assign o_hits    = res_hits_q;

endmodule

// File: tb/tb_det_scan_arbiter.sv
// Randomized self-checking bench for det_scan_arbiter against a transaction-level model.
// Expected hit counts follow DET_SCAN_OVERLAP_EN the same way the design does.
module tb_det_scan_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 8;
    localparam int CNT_W   = 4;
    localparam int ID_W    = $clog2(NUM_REQ);
`ifdef DET_SCAN_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ*WORD_W-1:0] i_word;
    logic [NUM_REQ-1:0]        o_gnt;
    logic                      o_busy, o_done, o_seq, o_det;
    logic [ID_W-1:0]           o_done_id;
    logic [CNT_W-1:0]          o_hits;

    always #5 clk = ~clk;

    det_scan_arbiter #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_word(i_word), .o_gnt(o_gnt),
        .o_busy(o_busy), .o_done(o_done), .o_done_id(o_done_id), .o_hits(o_hits),
        .o_seq(o_seq), .o_det(o_det)
    );

    int n_chk = 0, n_bad = 0, cyc = 0, c0 = 0;
    logic [NUM_REQ-1:0] want = '0, prev_req = '0;
    logic [WORD_W-1:0]  wd [NUM_REQ];
    bit                 hold_all = 1'b0;
    bit                 have_g = 1'b0;
    int                 g_cyc = 0, g_id = 0, g_hits = 0;
    logic [WORD_W-1:0]  g_word = '0;
    int                 rr = 0, hold_hits = 0, hold_id = 0;
    int                 last_hits = 0, last_id = 0;
    int                 gq[$], gcq[$], dq[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Count 1011 occurrences MSB-first; without overlap a match consumes all four bits.
    function automatic int hits_of(input logic [WORD_W-1:0] w);
        int n = 0;
        int i = WORD_W - 1;
        logic [3:0] win4;
        while (i >= 3) begin
            win4 = 4'(w >> (i - 3));
            if (win4 == 4'b1011) begin
                n++;
                i = i - (OVL ? 3 : 4);
            end else begin
                i--;
            end
        end
        return (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        logic [NUM_REQ-1:0] t;
        for (int i = 0; i < NUM_REQ; i++) begin
            t = r >> ((p + i) % NUM_REQ);
            if (t[0]) return (p + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        have_g = 1'b0; rr = 0; hold_hits = 0; hold_id = 0; prev_req = '0; want = '0;
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] exp_gnt;
        logic [WORD_W-1:0]  sh;
        bit free, busy_e, done_e;
        int win;
        @(posedge clk);
        #1;
        i_req = want;
        for (int k = 0; k < NUM_REQ; k++) i_word[k*WORD_W +: WORD_W] = wd[k];
        cyc++;
        exp_gnt = '0;
        free = !(have_g && (cyc - 1) <= g_cyc + WORD_W);
        if (free && prev_req != '0 && want != '0) begin
            win     = rr_pick(want, rr);
            exp_gnt = NUM_REQ'(1) << win;
            have_g  = 1'b1;
            g_cyc   = cyc;
            g_id    = win;
            g_word  = wd[ID_W'(win)];
            g_hits  = hits_of(g_word);
            rr      = (win + 1) % NUM_REQ;
        end
        busy_e = have_g && (cyc <= g_cyc + WORD_W + 1);
        done_e = have_g && (cyc == g_cyc + WORD_W + 1);
        if (done_e) begin
            hold_hits = g_hits;
            hold_id   = g_id;
        end
        @(negedge clk);
        chk("gnt", o_gnt, exp_gnt);
        chk("busy", o_busy, busy_e);
        chk("done", o_done, done_e);
        chk("hits", o_hits, hold_hits);
        if (done_e) chk("done_id", o_done_id, hold_id);
        if (have_g && cyc > g_cyc && cyc <= g_cyc + WORD_W) begin
            sh = g_word << (cyc - g_cyc - 1);
            chk("seq", o_seq, sh[WORD_W-1]);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_gnt[k]) begin
                gq.push_back(k);
                gcq.push_back(cyc);
            end
        end
        if (o_done) begin
            dq.push_back(cyc);
            last_hits = o_hits;
            last_id   = o_done_id;
        end
        prev_req = want;
        if (!hold_all) want = want & ~o_gnt;
    endtask

    task automatic run_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            step();
            if (want == '0 && !o_busy) break;
        end
        chk("drain_busy", o_busy, 0);
    endtask

    task automatic clr_q();
        gq.delete(); gcq.delete(); dq.delete();
    endtask

    task automatic serve(input int k, input logic [WORD_W-1:0] w);
        clr_q();
        wd[ID_W'(k)]   = w;
        want[ID_W'(k)] = 1'b1;
        c0 = cyc + 1;
        run_idle(60);
        chk("serve_ndone", dq.size(), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_req = '0; i_word = '0;
        for (int k = 0; k < NUM_REQ; k++) wd[k] = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_id", o_done_id, 0);
        chk("rst_hits", o_hits, 0);
        chk("rst_seq", o_seq, 0);
        chk("rst_det", o_det, 0);
        rst = 1'b0;

        serve(0, 8'hB0);
        if (gcq.size() > 0) chk("b0_gnt_lat", gcq[0] - c0, 1);
        if (dq.size() > 0)  chk("b0_done_lat", dq[0] - c0, WORD_W + 2);
        chk("b0_id", last_id, 0);
        chk("b0_hits", last_hits, 1);
        serve(0, 8'hB6);
        chk("b6_hits", last_hits, OVL ? 2 : 1);
        serve(0, 8'hFF);
        chk("ff_hits", last_hits, 0);
        serve(0, 8'h00);
        chk("00_hits", last_hits, 0);

        // Channel 2 arrives mid-scan of channel 0: served straight after DONE.
        clr_q();
        wd[0] = 8'h2D; want[0] = 1'b1;
        for (int i = 0; i < 20 && gq.size() == 0; i++) step();
        repeat (2) step();
        wd[2] = 8'hB6; want[2] = 1'b1;
        run_idle(60);
        chk("b2b_ngnt", gq.size(), 2);
        if (gq.size() > 1) chk("b2b_id", gq[1], 2);
        if (gcq.size() > 1 && dq.size() > 0) chk("b2b_gap", gcq[1] - dq[0], 1);

        // Reset asserted in the 4th SHIFT cycle of channel 1.
        serve(0, 8'hB6);
        clr_q();
        wd[1] = 8'hBB; want[1] = 1'b1;
        for (int i = 0; i < 20 && gq.size() == 0; i++) step();
        chk("mid_ngnt", gq.size(), 1);
        repeat (3) step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", o_gnt, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_id", o_done_id, 0);
        chk("arst_hits", o_hits, 0);
        chk("arst_seq", o_seq, 0);
        chk("arst_det", o_det, 0);
        model_reset();
        i_req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr_q();
        for (int k = 0; k < NUM_REQ; k++) wd[k] = WORD_W'($urandom);
        want = '1;
        run_idle(120);
        chk("post_rst_ngnt", gq.size(), NUM_REQ);
        if (gq.size() > 0) chk("post_rst_first", gq[0], 0);

        // All requests held high: strict rotation at one word per WORD_W+2 cycles.
        clr_q();
        for (int k = 0; k < NUM_REQ; k++) wd[k] = WORD_W'($urandom);
        want = '1; hold_all = 1'b1;
        for (int i = 0; i < 100 && gq.size() < 5; i++) step();
        want = '0; hold_all = 1'b0;
        run_idle(40);
        chk("hold_ngnt", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("hold_order", gq[i], i % NUM_REQ);
        for (int i = 1; i < dq.size(); i++) chk("hold_period", dq[i] - dq[i-1], WORD_W + 2);

        // Random traffic; a requester keeps its word until granted.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!want[k] && $urandom_range(0, 9) == 0) begin
                    want[k] = 1'b1;
                    wd[k]   = WORD_W'($urandom);
                end
            end
            step();
        end
        run_idle(NUM_REQ * (WORD_W + 2) + 20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
